mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit mux output bus among four requesters.
- Drives the 2-bit select of the 4:1 bus mux and presents the granted requester's data on the shared bus.
- Bounds each grant with a hold counter so that no requester is starved.
- Sits above the mux datapath as its select controller; replaces hand-driven select switches with a clocked scheduler.

Parameters:
- WIDTH, 5, data width of each requester input and of the shared bus.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus while others wait; legal range 2..256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i]=1 while requester i wants the bus.
- d0  input  WIDTH  data from requester 0.
- d1  input  WIDTH  data from requester 1.
- d2  input  WIDTH  data from requester 2.
- d3  input  WIDTH  data from requester 3.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered encoded owner index; drives the bus mux select.
- bus_out  output  WIDTH  shared bus: data of the current owner (d[sel]) when busy, else 0. Combinational from the registered sel/busy and the live d inputs.
- busy  output  1  registered; equals |gnt.

Behaviour:
Reset (rst=1 at a clk edge) forces:
- state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, hold_cnt=0.
- last=3, so the first search starts at requester 0.
- bus_out therefore reads 0 one cycle later. Reset overrides every other event, including mid-grant.

Winner search:
- pick(v, start): the first set bit of v scanning start, start+1, ... modulo 4.
- Normal search start = (last+1) mod 4.

IDLE:
- req==0: stay in IDLE.
- Otherwise: winner w=pick(req, last+1).
- Next edge: gnt=onehot(w), sel=w, busy=1, last=w, hold_cnt=0, state=BUSY.
- Latency is one cycle from a req edge to gnt.

BUSY, owner k:
- Voluntary release (req[k]==0):
  - If other requests are pending, w=pick(req, k+1); w is granted at the next edge with hold_cnt=0. Handover takes zero idle cycles.
  - If req==0, go to IDLE with gnt=0 and busy=0.
- Forced release (req[k]==1 and hold_cnt==MAX_HOLD-1):
  - w=pick(req, k+1); k is still eligible, but at lowest priority.
  - If k is the sole requester, k is re-granted and hold_cnt resets to 0; gnt is unchanged.
- Otherwise: hold_cnt increments and the grant is unchanged.

Invariants and rules:
- gnt is always one-hot or zero.
- sel changes only on grant transitions.
- A requester dropping req is released the following edge; bus_out may show its data for that one cycle.
- hold_cnt width = clog2(MAX_HOLD); it never exceeds MAX_HOLD-1.
- Simultaneous requests are resolved purely by rotating priority from last+1. No fixed priority exists.
- Requests arriving mid-grant wait; they do not preempt except via the MAX_HOLD limit.
- A req pulse shorter than one cycle, seen while idle, still yields a single one-cycle grant.

Test Plan:
1. Reset/idle: assert rst 2 cycles with req=4'b1111 -> gnt=0, sel=0, busy=0, bus_out=0. Deassert rst with req=0 for 5 cycles -> outputs stay 0.
2. Single grant: d2=5'h15, req=4'b0100 from cycle 0 -> gnt=4'b0100, sel=2, bus_out=5'h15 at cycle 1. Drop req at cycle 4 -> gnt=0, bus_out=0 at cycle 5.
3. Rotation: after reset, req=4'b1111 held, each owner dropping req for one cycle on receiving grant -> grant order 0,1,2,3,0 with no idle cycle between grants.
4. Starvation bound: req=4'b0011 held continuously, MAX_HOLD=8 -> requester 0 owns 8 cycles, then requester 1 owns 8 cycles, alternating. Check that hold_cnt never exceeds 7.
5. Sole holder: req=4'b1000 held for 20 cycles -> gnt stays 4'b1000 throughout; the re-grant every 8 cycles is invisible on gnt.
6. Reset mid-grant: owner 1 busy with req=4'b0110, assert rst for one cycle -> gnt=0 next edge. Release rst -> requester 1 wins, since last=3 gives start 0 and the first set bit is 1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler for a four-way shared bus: registers the grant/select and
// presents the owner's data, forcing a handover after MAX_HOLD cycles of contention.
module mux_rr_arbiter #(
  parameter int WIDTH    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [1:0]     last;
  logic [CW-1:0]  hold_cnt;
  logic [1:0]     next_w;
  logic           do_grant;

  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    // Scan from the far end down so the nearest set bit to start wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (v[idx]) pick = idx;
    end
  endfunction

  // While busy, last always equals the owner, so one search covers both states.
  always_comb begin
    next_w   = pick(req, last + 2'd1);
    do_grant = 1'b0;
    case (state)
      IDLE: do_grant = |req;
      BUSY: do_grant = (|req) && (!req[sel] || (hold_cnt == HOLD_LAST));
      default: do_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last     <= 2'd3;
    end else if (do_grant) begin
      state    <= BUSY;
      gnt      <= 4'b0001 << next_w;
      sel      <= next_w;
      busy     <= 1'b1;
      last     <= next_w;
      hold_cnt <= '0;
    end else if (state == BUSY) begin
      if (!req[sel]) begin
        state    <= IDLE;
        gnt      <= 4'b0000;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    bus_out = '0;
    if (busy) begin
      case (sel)
        2'd0: bus_out = d0;
        2'd1: bus_out = d1;
        2'd2: bus_out = d2;
        default: bus_out = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a behavioural model queues the expected
// registered outputs when stimulus is driven; they are popped after each edge.
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 5;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] bus_out;
  logic             busy;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .bus_out(bus_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] bus;
    int               cnt;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  int         m_owner = -1;
  int         m_last  = 3;
  int         m_cnt   = 0;
  logic [1:0] m_sel   = 2'd0;

  function automatic int ref_pick(input logic [3:0] v, input int start);
    for (int i = 0; i < 4; i++)
      if (v[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_grant(input logic [3:0] rq, input int start);
    int w;
    w       = ref_pick(rq, start);
    m_owner = w;
    m_last  = w;
    m_sel   = 2'(w);
    m_cnt   = 0;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    exp_t             e;
    logic [WIDTH-1:0] dv[4];
    rst = r; req = rq; d0 = a; d1 = b; d2 = c; d3 = d;
    dv = '{a, b, c, d};

    if (r) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 2'd0;
    end else if (m_owner < 0) begin
      if (rq != 4'b0) model_grant(rq, (m_last + 1) % 4);
    end else if (!rq[m_owner]) begin
      if (rq != 4'b0) model_grant(rq, (m_owner + 1) % 4);
      else begin m_owner = -1; m_cnt = 0; end
    end else if (m_cnt == MAX_HOLD - 1) begin
      model_grant(rq, (m_owner + 1) % 4);
    end else begin
      m_cnt++;
    end

    e.gnt  = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e.sel  = m_sel;
    e.busy = (m_owner >= 0);
    e.bus  = (m_owner < 0) ? '0 : dv[m_owner];
    e.cnt  = m_cnt;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("gnt",        32'(gnt),          32'(e.gnt));
    checkOutput("sel",        32'(sel),          32'(e.sel));
    checkOutput("busy",       32'(busy),         32'(e.busy));
    checkOutput("bus_out",    32'(bus_out),      32'(e.bus));
    checkOutput("hold_cnt",   32'(dut.hold_cnt), 32'(e.cnt));
    checkOutput("hold_bound", 32'(dut.hold_cnt <= 3'(MAX_HOLD - 1)), 32'd1);
  endtask

  initial begin
    logic [3:0] rq;
    rst = 1'b1; req = 4'b0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset with every requester asking, then idle
    repeat (2) applyStimulus(1'b1, 4'b1111, 5'h01, 5'h02, 5'h03, 5'h04);
    checkOutput("t1_gnt",  32'(gnt),  32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    repeat (5) applyStimulus(1'b0, 4'b0000, 5'h01, 5'h02, 5'h03, 5'h04);
    checkOutput("t1_bus_idle", 32'(bus_out), 32'd0);

    // Single grant to requester 2
    applyStimulus(1'b0, 4'b0100, 5'h00, 5'h00, 5'h15, 5'h00);
    checkOutput("t2_gnt", 32'(gnt),     32'h4);
    checkOutput("t2_sel", 32'(sel),     32'd2);
    checkOutput("t2_bus", 32'(bus_out), 32'h15);
    repeat (3) applyStimulus(1'b0, 4'b0100, 5'h00, 5'h00, 5'h15, 5'h00);
    applyStimulus(1'b0, 4'b0000, 5'h00, 5'h00, 5'h15, 5'h00);
    checkOutput("t2_rel_gnt", 32'(gnt),     32'd0);
    checkOutput("t2_rel_bus", 32'(bus_out), 32'd0);

    // Rotation: each owner drops its request for one cycle
    applyStimulus(1'b1, 4'b0000, 5'h0a, 5'h0b, 5'h0c, 5'h0d);
    for (int k = 0; k < 5; k++) begin
      rq = (k == 0) ? 4'b1111 : (4'b1111 & ~(4'b0001 << ((k - 1) % 4)));
      applyStimulus(1'b0, rq, 5'h0a, 5'h0b, 5'h0c, 5'h0d);
      checkOutput("t3_order", 32'(sel),  32'(k % 4));
      checkOutput("t3_busy",  32'(busy), 32'd1);
    end
    applyStimulus(1'b0, 4'b0000, 5'h0a, 5'h0b, 5'h0c, 5'h0d);

    // Starvation bound: two contenders alternate every MAX_HOLD cycles
    applyStimulus(1'b1, 4'b0000, 5'h11, 5'h12, 5'h13, 5'h14);
    for (int n = 0; n < 34; n++) begin
      applyStimulus(1'b0, 4'b0011, 5'h11, 5'h12, 5'h13, 5'h14);
      checkOutput("t4_owner", 32'(sel), 32'((n / MAX_HOLD) % 2));
    end

    // Sole holder keeps the bus with no visible re-grant
    applyStimulus(1'b1, 4'b0000, 5'h11, 5'h12, 5'h13, 5'h1f);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 4'b1000, 5'h11, 5'h12, 5'h13, 5'h1f);
      checkOutput("t5_gnt", 32'(gnt), 32'h8);
    end

    // Reset in the middle of a grant
    applyStimulus(1'b1, 4'b0000, 5'h05, 5'h06, 5'h07, 5'h08);
    repeat (3) applyStimulus(1'b0, 4'b0110, 5'h05, 5'h06, 5'h07, 5'h08);
    checkOutput("t6_owner", 32'(gnt), 32'h2);
    applyStimulus(1'b1, 4'b0110, 5'h05, 5'h06, 5'h07, 5'h08);
    checkOutput("t6_rst_gnt", 32'(gnt), 32'd0);
    applyStimulus(1'b0, 4'b0110, 5'h05, 5'h06, 5'h07, 5'h08);
    checkOutput("t6_regrant", 32'(gnt), 32'h2);

    // One-cycle request pulse while idle gives a one-cycle grant
    applyStimulus(1'b1, 4'b0000, 5'h05, 5'h06, 5'h07, 5'h08);
    applyStimulus(1'b0, 4'b0001, 5'h05, 5'h06, 5'h07, 5'h08);
    checkOutput("t7_pulse_gnt", 32'(gnt), 32'h1);
    applyStimulus(1'b0, 4'b0000, 5'h05, 5'h06, 5'h07, 5'h08);
    checkOutput("t7_pulse_rel", 32'(gnt), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
